// File: rtl/mux_accum.sv
// Multi-channel selecting accumulator: per job, sums `len` beats taken from one of
// NCH channels (explicit select or round-robin) onto a carry-in, with a sticky overflow flag.
module mux_accum #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [7:0]                   len,
    input  logic                         cin,
    input  logic                         mode,
    input  logic [$clog2(NCH)-1:0]       sel,
    input  logic [NCH*WIDTH-1:0]         ch_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_sum,
    output logic                         out_ovf,
    output logic                         busy
);
    localparam int SELW = $clog2(NCH);
    localparam int NPAD = 1 << SELW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        len_q, len_d;
    logic              mode_q, mode_d;
    logic [SELW-1:0]   rr_q, rr_d;

    // Channel table padded to a power of two; out-of-range selects alias channel 0.
    logic [WIDTH-1:0]  ch_pad [NPAD];

    for (genvar k = 0; k < NPAD; k++) begin : g_pad
        if (k < NCH) begin : g_real
            assign ch_pad[k] = ch_data[k*WIDTH +: WIDTH];
        end else begin : g_alias
            assign ch_pad[k] = ch_data[WIDTH-1:0];
        end
    end

    logic [SELW-1:0]   op_idx;
    logic [WIDTH-1:0]  operand;
    logic [WIDTH:0]    sum_ext;

    assign op_idx  = mode_q ? rr_q : sel;
    assign operand = ch_pad[op_idx];
    assign sum_ext = {1'b0, acc_q} + {1'b0, operand};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = WIDTH'(cin);
                    ovf_d   = 1'b0;
                    cnt_d   = 8'd0;
                    rr_d    = '0;
                    len_d   = len;
                    mode_d  = mode;
                    state_d = (len == 8'd0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_d = sum_ext[WIDTH-1:0];
                    ovf_d = ovf_q | sum_ext[WIDTH];
                    cnt_d = cnt_q + 8'd1;
                    if (mode_q) begin
                        rr_d = (rr_q == SELW'(NCH-1)) ? '0 : rr_q + 1'b1;
                    end
                    if (cnt_d == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 8'd0;
            len_q   <= 8'd0;
            mode_q  <= 1'b0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            rr_q    <= rr_d;
        end
    end

    // Result is only exposed in DONE so the outputs read zero outside a valid result.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = out_valid ? acc_q : '0;
    assign out_ovf   = out_valid & ovf_q;

endmodule

// File: tb/tb_mux_accum.sv
// Directed bench for mux_accum: transaction-level model of the job rules, a per-cycle
// compare process, and literal expectations for each directed job.
module tb_mux_accum;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = $clog2(NCH);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [7:0]             len;
    logic                   cin;
    logic                   mode;
    logic [SELW-1:0]        sel;
    logic [NCH*WIDTH-1:0]   ch_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_sum;
    logic                   out_ovf;
    logic                   busy;

    mux_accum #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .cin(cin), .mode(mode),
        .sel(sel), .ch_data(ch_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: phase 0 idle, 1 collecting operands, 2 holding a result
    int m_ph   = 0;
    int m_acc  = 0;
    int m_ovf  = 0;
    int m_cnt  = 0;
    int m_len  = 0;
    int m_mode = 0;
    int m_rr   = 0;
    int ch_v [NCH];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", int'(in_ready), int'(m_ph == 1));
            chk("out_valid", int'(out_valid), int'(m_ph == 2));
            chk("busy", int'(busy), int'(m_ph != 0));
            if (m_ph == 2) begin
                chk("out_sum", int'(out_sum), m_acc);
                chk("out_ovf", int'(out_ovf), m_ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int a, input int b, input int c, input int d);
        ch_v[0] = a; ch_v[1] = b; ch_v[2] = c; ch_v[3] = d;
        for (int k = 0; k < NCH; k++) ch_data[k*WIDTH +: WIDTH] = WIDTH'(ch_v[k]);
    endtask

    task automatic start_job(input int l, input int c, input int md);
        start = 1'b1; len = 8'(l); cin = c[0]; mode = md[0];
        tick();
        start = 1'b0;
        if (m_ph == 0) begin
            m_acc = c; m_ovf = 0; m_cnt = 0; m_rr = 0; m_len = l; m_mode = md;
            m_ph  = (l == 0) ? 2 : 1;
        end
    endtask

    task automatic beat(input int s, input int v);
        int op, sum;
        sel = SELW'(s); in_valid = v[0];
        op = 0;
        if (m_ph == 1 && v != 0)
            op = (m_mode != 0) ? ch_v[m_rr] : ((s < NCH) ? ch_v[s] : ch_v[0]);
        tick();
        in_valid = 1'b0;
        if (m_ph == 1 && v != 0) begin
            sum   = m_acc + op;
            m_ovf = (sum >= (1 << WIDTH)) ? 1 : m_ovf;
            m_acc = sum % (1 << WIDTH);
            m_cnt++;
            m_rr  = (m_rr + 1) % NCH;
            if (m_cnt == m_len) m_ph = 2;
        end
    endtask

    // Literal pin of the directed result, then consume it.
    task automatic finish_job(input string name, input int e_sum, input int e_ovf);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_sum"}, int'(out_sum), e_sum);
        chk({name, "_ovf"}, int'(out_ovf), e_ovf);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (m_ph == 2) m_ph = 0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = 8'd0; cin = 1'b0; mode = 1'b0; sel = '0;
        ch_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        set_ch(0, 0, 0, 0);
        #12;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // select mode, ch2 = 10,20,30, cin=1
        start_job(3, 1, 0);
        set_ch(0, 0, 10, 0); beat(2, 1);
        set_ch(0, 0, 20, 0); beat(2, 1);
        set_ch(0, 0, 30, 0); beat(2, 1);
        finish_job("sel3", 61, 0);

        // round robin over 1,2,4,8
        set_ch(1, 2, 4, 8);
        start_job(6, 0, 1);
        for (int i = 0; i < 6; i++) beat(3, 1);
        finish_job("rr6", 18, 0);
        start_job(2, 0, 1);
        beat(0, 1); beat(0, 1);
        finish_job("rr_restart", 3, 0);

        // overflow then sticky cleared
        set_ch(0, 200, 0, 0);
        start_job(2, 0, 0);
        beat(1, 1); beat(1, 1);
        finish_job("ovf", 144, 1);
        set_ch(0, 0, 0, 5);
        start_job(1, 0, 0);
        beat(3, 1);
        finish_job("ovf_clr", 5, 0);

        // empty job, result held, start ignored in DONE
        start_job(0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); len = 8'd3;
            tick();
        end
        start = 1'b0;
        finish_job("len0", 1, 0);

        // bubbles and start during ACC
        set_ch(0, 0, 0, 7);
        start_job(3, 0, 0);
        beat(3, 1);
        start = 1'b1; len = 8'd0; cin = 1'b1;
        beat(3, 0);
        start = 1'b0;
        beat(3, 1); beat(3, 0); beat(3, 1);
        finish_job("bubble", 21, 0);

        // reset mid-job
        set_ch(100, 50, 9, 9);
        start_job(4, 1, 1);
        beat(0, 1); beat(0, 1);
        #2 rst_n = 1'b0;
        #1;
        m_ph = 0;
        chk("arst_in_ready", int'(in_ready), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_sum", int'(out_sum), 0);
        chk("arst_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        start_job(2, 1, 1);
        beat(0, 1); beat(0, 1);
        finish_job("post_rst", 151, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mux_accum.md
# mux_accum

Parametrised multi-channel selecting accumulator, the sequential successor to the team's 2:1 mux and 3-bit carry adder. Each accepted beat selects one of NCH input channels, either by explicit select or by an internal round-robin pointer, and adds it into a running WIDTH-bit sum that starts from a carry-in. A valid/ready handshake on input and output lets the block sit between a channel source and a downstream consumer. It produces one sum and a sticky overflow flag per programmed job of `len` operands.

## Interface
Parameters:
- WIDTH, 8, data and sum width in bits (≥2)
- NCH, 4, number of input channels (≥2); SELW = $clog2(NCH) is a localparam

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job start pulse; sampled only in IDLE
- len  in  8  operand count for the job; latched on start
- cin  in  1  carry-in; latched on start as the initial sum value
- mode  in  1  0 = use `sel` per beat, 1 = round-robin; latched on start
- sel  in  SELW  channel select; used per beat when mode=0
- ch_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH  accumulated sum modulo 2^WIDTH
- out_ovf  out  1  sticky: set if any addition in the job carried out of WIDTH bits
- busy  out  1  high in ACC or DONE

## Operation
- FSM states: IDLE, ACC, DONE. Reset state is IDLE.
- IDLE: in_ready=0, out_valid=0.
  - On start: acc←{0…,cin}, ovf←0, cnt←0, rr←0; latch len, mode.
  - If len==0, go to DONE, so the result is sum=cin and ovf=0. Otherwise go to ACC.
- ACC: in_ready=1.
  - On in_valid&&in_ready: operand = mode ? ch[rr] : ch[sel].
  - {c,acc}←acc+operand (WIDTH+1-bit add); ovf←ovf|c; cnt←cnt+1.
  - If mode=1: rr←(rr==NCH-1)?0:rr+1.
  - When the accepted beat makes cnt==len, go to DONE.
- sel≥NCH, possible only when NCH is not a power of 2, selects ch[0].
- DONE: out_valid=1; out_sum=acc and out_ovf=ovf, both held stable. On out_ready, go to IDLE.
- start is ignored in ACC and DONE.
- Round-robin pointer rr: restarts at 0 on every job and advances only on accepted beats.
- Reset at any time: immediately returns to IDLE and clears all outputs; a partial job is discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- All outputs are registered or decoded from the state register. There is no combinational path from in_valid or out_ready to any output.
- start sampled at edge N → ACC, in_ready=1 and busy=1 from cycle N+1.
- Throughput is one operand per cycle while in_valid is held high.
- Last beat accepted at edge M → out_valid=1 from cycle M+1. in_ready=0 from M+1.
- len==0: start at edge N → out_valid=1 in cycle N+1.
- out_valid&&out_ready at edge P → IDLE from P+1. A start is first sampled at edge P+1, so back-to-back jobs have a 1-cycle IDLE gap.
- in_valid low in ACC inserts a bubble; state and rr are held.
- Job latency = len accepted beats + 1 cycle to out_valid.

## Test plan
- WIDTH=8, NCH=4, mode=0, cin=1, len=3, sel=2 with ch2=10,20,30 on consecutive beats → out_sum=61, out_ovf=0; out_valid one cycle after the third beat.
- mode=1, len=6, cin=0, ch0..3=1,2,4,8 held constant → operands ch0,1,2,3,0,1 → out_sum=18. Second job: rr restarts at ch0.
- mode=0, len=2, ch1=200 twice → out_sum=144, out_ovf=1. Next job with len=1 and operand 5 → out_ovf=0 (sticky cleared on start).
- len=0, cin=1 → out_valid the cycle after start, out_sum=1, out_ovf=0. Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0, start ignored.
- in_valid toggled 1,0,1,0,1 with len=3 → exactly 3 beats accepted, correct sum. start pulsed during ACC is ignored.
- Assert rst_n=0 mid-job after 2 of 4 beats → asynchronously in_ready=0, out_valid=0, out_sum=0, busy=0. A fresh job after reset release produces the correct result.
